seg_scan_driver: RTL

Multiplexed seven-segment display driver that sits directly downstream of the one-hot ring counter. Each cycle it takes the ring counter's one-hot digit select, picks the matching 4-bit digit from a frame-stable value register, and drives registered active-low segment and digit-enable outputs. A valid/ready load port double-buffers new display values so that a value only goes live at a frame boundary, which prevents tearing. The block also flags a corrupted (non-one-hot) select.

---
 rtl/seg_scan_driver.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//
// Multiplexed seven-segment display driver fed by a one-hot ring counter.
// Every cycle the digit picked by ring_in is fetched from a frame-stable
// value register (active), decoded to segments and registered onto the
// active-low outputs. New display values arrive through a valid/ready port
// into a shadow register. They are copied into active only at a frame
// boundary, so a frame never mixes old and new digits.
//
// Ports:
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   ring_in     one-hot digit select; bit WIDTH-1 is the most significant digit
//   load_data   new display value, nibble i is digit i
//   load_valid  load_data is valid
//   load_ready  a load can be accepted (no value waiting for a frame boundary)
//   seg_n       active-low segments {g,f,e,d,c,b,a}, registered
//   dig_n       active-low digit enables, registered
//   onehot_err  sticky: ring_in was seen with zero or several bits set
//
// Parameters:
//   WIDTH       number of digits (must match the ring counter)
//   BLANK_LZ    1 blanks leading zeros, 0 shows every digit

module seg_scan_driver #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WIDTH-1:0]   ring_in,
    input  logic [4*WIDTH-1:0] load_data,
    input  logic               load_valid,
    output logic               load_ready,
    output logic [6:0]         seg_n,
    output logic [WIDTH-1:0]   dig_n,
    output logic               onehot_err
);

    localparam logic [WIDTH-1:0] RingFirst = WIDTH'(1);
    localparam logic [6:0]       SegBlank  = 7'h7f;

    // State
    logic [4*WIDTH-1:0] shadow_q, shadow_d;
    logic [4*WIDTH-1:0] active_q, active_d;
    logic               pending_q, pending_d;
    logic [WIDTH-1:0]   prev_ring_q, prev_ring_d;
    logic [6:0]         seg_n_q, seg_n_d;
    logic [WIDTH-1:0]   dig_n_q, dig_n_d;
    logic               onehot_err_q, onehot_err_d;

    // Combinational helpers
    logic               ring_onehot;
    logic               frame_start;
    logic               accept;
    logic               commit;
    logic [4*WIDTH-1:0] disp_val;
    logic [WIDTH-1:0]   lz_blank;
    logic               zero_above;
    logic [3:0]         sel_nibble;
    logic               sel_blank;

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'ha: s = 7'b0001000;
            4'hb: s = 7'b0000011;
            4'hc: s = 7'b1000110;
            4'hd: s = 7'b0100001;
            4'he: s = 7'b0000110;
            4'hf: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Handshake, frame boundary and value registers
    always_comb begin
        // x & (x-1) clears the lowest set bit; zero result means at most one bit set.
        ring_onehot = (ring_in != '0) && ((ring_in & (ring_in - RingFirst)) == '0);
        // A held 0001 produces only one boundary; a corrupted select never matches.
        frame_start = (ring_in == RingFirst) && (prev_ring_q != RingFirst);
        commit      = frame_start && pending_q;
        // Accept needs pending low, so it can never coincide with a commit.
        accept      = load_valid && !pending_q;

        shadow_d    = shadow_q;
        active_d    = active_q;
        pending_d   = pending_q;
        prev_ring_d = ring_in;

        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        // The boundary sample already displays the new frame's digit 0, so
        // it must see the value being committed this cycle.
        disp_val = commit ? shadow_q : active_q;
    end

    // Leading-zero mask: scanning down from the MSD, a digit is blanked while
    // it and everything above it are zero. Digit 0 always shows.
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            zero_above  = zero_above && (disp_val[4*i +: 4] == 4'h0);
            lz_blank[i] = (BLANK_LZ != 0) && (i > 0) && zero_above;
        end
    end

    // Digit select, decode and output next-state
    always_comb begin
        sel_nibble = 4'h0;
        sel_blank  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                sel_nibble = disp_val[4*i +: 4];
                sel_blank  = lz_blank[i];
            end
        end

        seg_n_d      = SegBlank;
        dig_n_d      = '1;
        onehot_err_d = onehot_err_q;

        if (ring_onehot) begin
            dig_n_d = ~ring_in;
            seg_n_d = sel_blank ? SegBlank : hex_to_seg(sel_nibble);
        end else begin
            // Corrupted select: dark display and a sticky error.
            onehot_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            prev_ring_q  <= '0;
            seg_n_q      <= SegBlank;
            dig_n_q      <= '1;
            onehot_err_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            prev_ring_q  <= prev_ring_d;
            seg_n_q      <= seg_n_d;
            dig_n_q      <= dig_n_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    assign load_ready = !pending_q;
    assign seg_n      = seg_n_q;
    assign dig_n      = dig_n_q;
    assign onehot_err = onehot_err_q;

endmodule
